// File: rtl/kgp_risc_pkg.sv
// Shared constants for the KGP_RISC datapath: machine word width and the
// state encoding used by the shared-adder arbiter.
package kgp_risc_pkg;

  // Machine word width of the core.
  localparam int XLEN = 32;

  // Arbiter FSM state encoding.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Width of a requester tag: clog2(n), never below one bit.
  function automatic int tag_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hybrid_adder.sv
// Hybrid adder: 4-bit carry-lookahead groups whose group carries ripple from
// one group to the next. Unsigned a + b with carry out.
// WIDTH must be a multiple of 4.
module hybrid_adder
  import kgp_risc_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NUM_GRP = WIDTH / 4;

  // w_carry[g] is the carry into group g; w_carry[NUM_GRP] is the final carry.
  logic [NUM_GRP:0] w_carry;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;

  assign w_carry[0] = 1'b0;
  assign w_p        = a ^ b;
  assign w_g        = a & b;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GRP; gi++) begin : g_cla
      logic [3:0] w_gp;
      logic [3:0] w_gg;
      logic [3:0] w_c;
      logic       w_cin;

      assign w_gp  = w_p[gi*4 +: 4];
      assign w_gg  = w_g[gi*4 +: 4];
      assign w_cin = w_carry[gi];

      // Lookahead carries inside the group, all derived from the group carry-in.
      assign w_c[0] = w_cin;
      assign w_c[1] = w_gg[0] | (w_gp[0] & w_cin);
      assign w_c[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & w_cin);
      assign w_c[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                    | (w_gp[2] & w_gp[1] & w_gp[0] & w_cin);

      assign w_carry[gi+1] = w_gg[3] | (w_gp[3] & w_gg[2])
                           | (w_gp[3] & w_gp[2] & w_gg[1])
                           | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                           | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & w_cin);

      assign sum[gi*4 +: 4] = w_gp ^ w_c;
    end
  endgenerate

  assign cout = w_carry[NUM_GRP];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that time-shares one hybrid_adder between NUM_REQ
// requesters. A grant latches the operands, the add runs in the next cycle,
// and the tagged result is held until the consumer takes it.
module adder_arbiter
  import kgp_risc_pkg::*;
#(
  parameter int WIDTH   = XLEN,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = tag_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
);

  // First valid index at or after ptr, scanning modulo NUM_REQ; one-hot result.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [ID_W-1:0]    ptr);
    logic [NUM_REQ-1:0] grant;
    logic               found;
    int                 idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

  // Index of the set bit of a one-hot vector (zero when empty).
  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [ID_W-1:0]    r_op_id;
  logic [WIDTH-1:0]   r_rsp_sum;
  logic               r_rsp_cout;
  logic [ID_W-1:0]    r_rsp_id;

  logic               w_any_valid;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic [ID_W-1:0]    w_rr_ptr_next;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic               w_accept;
  logic [WIDTH-1:0]   w_add_sum;
  logic               w_add_cout;

  // Per-requester operand slices.
  logic [WIDTH-1:0]   w_a_slice [NUM_REQ];
  logic [WIDTH-1:0]   w_b_slice [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_a_slice[gi] = req_a[gi*WIDTH +: WIDTH];
      assign w_b_slice[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_any_valid   = |req_valid;
  assign w_grant       = rr_pick(req_valid, r_rr_ptr);
  assign w_grant_idx   = onehot_to_idx(w_grant);
  assign w_rr_ptr_next = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
  assign w_accept      = (r_state == S_IDLE) && w_any_valid;

  // AND-OR mux of the granted requester's operands.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a = w_sel_a | w_a_slice[i];
        w_sel_b = w_sel_b | w_b_slice[i];
      end
    end
  end

  // The single shared adder always looks at the latched operands.
  hybrid_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (r_op_a),
    .b    (r_op_b),
    .sum  (w_add_sum),
    .cout (w_add_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state logic: IDLE -> ADD -> RESP -> IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_valid) w_state_next = S_ADD;
      S_ADD:   w_state_next = S_RESP;
      S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; grant is also forced low while reset is held.
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy      = 1'b0;
        req_ready = rst ? w_grant : '0;
      end
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand latch and round-robin pointer update on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op_id  <= '0;
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_op_a   <= w_sel_a;
      r_op_b   <= w_sel_b;
      r_op_id  <= w_grant_idx;
      r_rr_ptr <= w_rr_ptr_next;
    end
  end

  // Capture the adder result during ADD; held unchanged through RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_sum  <= '0;
      r_rsp_cout <= 1'b0;
      r_rsp_id   <= '0;
    end else if (r_state == S_ADD) begin
      r_rsp_sum  <= w_add_sum;
      r_rsp_cout <= w_add_cout;
      r_rsp_id   <= r_op_id;
    end
  end

  assign rsp_sum  = r_rsp_sum;
  assign rsp_cout = r_rsp_cout;
  assign rsp_id   = r_rsp_id;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter (2 requesters, 32-bit).
module tb_adder_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 32;

  logic             clk;
  logic             rst;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]  req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_sum;
  logic             rsp_cout;
  logic [0:0]       rsp_id;
  logic             busy;

  int total = 0;
  int bad   = 0;

  adder_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A job is either absent (arbiter free) or present with an age counting
  // clock edges since it was accepted; the result is visible from age 2.
  logic        m_job;
  int          m_age;
  int          m_ptr;
  logic [32:0] m_res;
  int          m_id;

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    int r;
    r = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (r < 0 && v[(p + k) % NREQ]) r = (p + k) % NREQ;
    end
    return r;
  endfunction

  function automatic logic [32:0] model_sum(input int i);
    return {1'b0, req_a[i*W +: W]} + {1'b0, req_b[i*W +: W]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_job <= 1'b0;
      m_age <= 0;
      m_ptr <= 0;
      m_res <= '0;
      m_id  <= 0;
    end else if (m_job) begin
      if (m_age >= 2 && rsp_ready) m_job <= 1'b0;
      else if (m_age < 2)          m_age <= m_age + 1;
    end else if (pick(req_valid, m_ptr) >= 0) begin
      m_job <= 1'b1;
      m_age <= 1;
      m_id  <= pick(req_valid, m_ptr);
      m_res <= model_sum(pick(req_valid, m_ptr));
      m_ptr <= (pick(req_valid, m_ptr) + 1) % NREQ;
    end
  end

  function automatic logic [NREQ-1:0] exp_ready();
    int g;
    g = pick(req_valid, m_ptr);
    if (!rst || m_job || g < 0) return '0;
    return NREQ'(1 << g);
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_rsp_sum", rsp_sum, 0);
    end else begin
      check("m_req_ready", req_ready, exp_ready());
      check("m_busy", busy, m_job);
      check("m_rsp_valid", rsp_valid, (m_job && m_age >= 2));
      if (m_job && m_age >= 2) begin
        check("m_rsp_sum", rsp_sum, m_res[31:0]);
        check("m_rsp_cout", rsp_cout, m_res[32]);
        check("m_rsp_id", rsp_id, m_id);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_grant();
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("grant_timeout", (req_ready != '0), 1);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("rsp_timeout", rsp_valid, 1);
  endtask

  task automatic run_one(input string tag, input logic [1:0] v,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [31:0] e_sum, input logic e_cout, input logic e_id);
    int n;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    wait_grant();
    @(posedge clk); #1;
    // Operand changes after acceptance must not reach the result.
    req_valid = 2'b00;
    req_a     = {$urandom, $urandom};
    req_b     = {$urandom, $urandom};
    wait_rsp(n);
    $display("txn %s: id=%0d sum=%08h cout=%0d", tag, rsp_id, rsp_sum, rsp_cout);
    check({tag, "_sum"}, rsp_sum, e_sum);
    check({tag, "_cout"}, rsp_cout, e_cout);
    check({tag, "_id"}, rsp_id, e_id);
  endtask

  initial begin
    int n;
    int cnt;
    int ids [4];
    int cyc [4];

    // 1: reset with random inputs
    rst       = 1'b0;
    req_valid = 2'($urandom);
    req_a     = {$urandom, $urandom};
    req_b     = {$urandom, $urandom};
    rsp_ready = 1'($urandom);
    repeat (3) @(negedge clk);
    check("t1_req_ready", req_ready, 0);
    check("t1_rsp_valid", rsp_valid, 0);
    check("t1_busy", busy, 0);
    check("t1_rsp_sum", rsp_sum, 0);
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;

    // 2: single add, exact latency
    @(posedge clk); #1;
    req_valid = 2'b01;
    req_a     = {32'd0, 32'd2};
    req_b     = {32'd0, 32'd3};
    @(negedge clk);
    check("t2_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check("t2_add_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_sum", rsp_sum, 32'd5);
    check("t2_cout", rsp_cout, 0);
    check("t2_id", rsp_id, 0);
    $display("txn t2: id=%0d sum=%08h cout=%0d", rsp_id, rsp_sum, rsp_cout);
    @(negedge clk);
    check("t2_idle_after", busy, 0);

    // 3: bit pattern and carry wrap
    run_one("t3_pat", 2'b01, {32'd0, 32'h55555555}, {32'd0, 32'h2AAAAAAA},
            32'h7FFFFFFF, 1'b0, 1'b0);
    run_one("t3_wrap", 2'b10, {32'hFFFFFFFF, 32'd0}, {32'd1, 32'd0},
            32'h0, 1'b1, 1'b1);

    // 4: contention, both valid held
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    req_a     = {32'd10, 32'd20};
    req_b     = {32'd1, 32'd2};
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready && cnt < 4) begin
        ids[cnt] = int'(rsp_id);
        cyc[cnt] = i;
        $display("txn t4: id=%0d sum=%08h cycle=%0d", rsp_id, rsp_sum, i);
        cnt++;
      end
    end
    check("t4_count", cnt, 4);
    check("t4_id0", ids[0], 0);
    check("t4_id1", ids[1], 1);
    check("t4_id2", ids[2], 0);
    check("t4_id3", ids[3], 1);
    for (int k = 0; k < 3; k++) check("t4_spacing", cyc[k+1] - cyc[k], 3);
    @(posedge clk); #1;
    req_valid = 2'b00;
    n = 0;
    @(negedge clk);
    while (busy && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("t4_drain", busy, 0);

    // 5: backpressure in RESP
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    req_a     = {32'd5, 32'd100};
    req_b     = {32'd6, 32'd23};
    wait_grant();
    @(posedge clk); #1;
    req_valid = 2'b10;
    wait_rsp(n);
    for (int k = 0; k < 5; k++) begin
      check("t5_rsp_valid", rsp_valid, 1);
      check("t5_sum", rsp_sum, 32'd123);
      check("t5_id", rsp_id, 0);
      check("t5_req_ready", req_ready, 0);
      check("t5_busy", busy, 1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    check("t5_last_valid", rsp_valid, 1);
    $display("txn t5: id=%0d sum=%08h cout=%0d", rsp_id, rsp_sum, rsp_cout);
    @(negedge clk);
    check("t5_done_valid", rsp_valid, 0);
    check("t5_done_busy", busy, 0);

    // 6: reset while in ADD, then pointer restarts at 0
    @(posedge clk); #1;
    req_valid = 2'b01;
    req_a     = {32'd0, 32'd1};
    req_b     = {32'd0, 32'd1};
    wait_grant();
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_busy", busy, 0);
    @(negedge clk);
    check("t6_rsp_valid2", rsp_valid, 0);
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = 2'b11;
    req_a     = {32'd4, 32'd3};
    req_b     = {32'd4, 32'd3};
    @(negedge clk);
    check("t6_first_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_rsp(n);
    $display("txn t6: id=%0d sum=%08h cout=%0d", rsp_id, rsp_sum, rsp_cout);
    check("t6_sum", rsp_sum, 32'd6);
    check("t6_id", rsp_id, 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
